hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage CPU. It drives the enables and bubble/flush controls of the PC, IF_ID, ID_EX and EX_MEM registers. It handles three events:
- load-use data hazards,
- taken-branch flushes,
- multi-cycle EX operations (mult/div), which freeze the front end for a fixed latency.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/mc_latency_counter.sv | 30 +++
 rtl/hazard_stall_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Holds the controller state encoding, the architectural zero register,
// the legal multi-cycle latency range and the bundle of pipeline controls.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_BUSY = 1'b1
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MC_LATENCY_MIN = 2;
    localparam int unsigned MC_LATENCY_MAX = 16;

    // Enables / bubble controls driven into the pipeline registers.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_bubble;
    } pipe_ctrl_t;

    // Everything advances, nothing is squashed.
    function automatic pipe_ctrl_t ctrl_normal();
        pipe_ctrl_t c;
        c.pc_en         = 1'b1;
        c.if_id_en      = 1'b1;
        c.if_id_flush   = 1'b0;
        c.id_ex_en      = 1'b1;
        c.id_ex_bubble  = 1'b0;
        c.ex_mem_bubble = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/mc_latency_counter.sv
// Load/decrement down-counter tracking the remaining multi-cycle EX time.
// Ports: clk, rst (sync active-low), i_load/i_load_val load a new count,
//        i_dec decrements (stops at zero), o_zero flags a zero count.
module mc_latency_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over decrement; decrement never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage CPU: drives PC / IF_ID /
// ID_EX / EX_MEM enables and bubble/flush controls for load-use hazards,
// taken-branch flushes and fixed-latency multi-cycle EX operations.
// Priority: multi-cycle stall > branch flush > load-use stall > normal.
// Outputs are combinational from state, count and inputs (zero latency).
// Ports:
//   clk, rst (sync active-low)
//   id_rs, id_rt, id_uses_rt          : source fields of the ID instruction
//   ex_mem_read, ex_rt                : load in EX and its destination
//   ex_multicycle, ex_branch_taken    : EX-stage events
//   pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble
//   mc_busy                           : controller is in MC_BUSY
// Optional (macro HAZ_STATS_EN): stall_cycles, flush_count saturating
// 16-bit statistics counters.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_multicycle,
    input  logic        ex_branch_taken,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_bubble,
    output logic        ex_mem_bubble,
    output logic        mc_busy
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [CNT_W-1:0] MC_LOAD_VAL = CNT_W'(MC_LATENCY - 2);

    ctrl_state_e r_state;
    ctrl_state_e w_next_state;
    pipe_ctrl_t  w_ctrl;
    logic        w_load_use;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_cnt_zero;

    // Load-use: a load in EX whose destination feeds the ID instruction.
    assign w_load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    mc_latency_counter #(
        .CNT_W (CNT_W)
    ) u_mc_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_load_val (MC_LOAD_VAL),
        .o_zero     (w_cnt_zero)
    );

    // Next-state and pipeline control decode.
    always_comb begin
        w_ctrl       = ctrl_normal();
        w_next_state = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;

        if (!rst) begin
            // Neutral controls while held in reset.
            w_next_state = ST_RUN;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (ex_multicycle) begin
                        w_ctrl.pc_en         = 1'b0;
                        w_ctrl.if_id_en      = 1'b0;
                        w_ctrl.id_ex_en      = 1'b0;
                        w_ctrl.ex_mem_bubble = 1'b1;
                        w_next_state         = ST_MC_BUSY;
                        w_cnt_load           = 1'b1;
                    end else if (ex_branch_taken) begin
                        w_ctrl.if_id_flush  = 1'b1;
                        w_ctrl.id_ex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_ctrl.pc_en        = 1'b0;
                        w_ctrl.if_id_en     = 1'b0;
                        w_ctrl.id_ex_bubble = 1'b1;
                    end
                end
                ST_MC_BUSY: begin
                    // Hazard/branch inputs are not evaluated while EX is occupied.
                    if (!w_cnt_zero) begin
                        w_ctrl.pc_en         = 1'b0;
                        w_ctrl.if_id_en      = 1'b0;
                        w_ctrl.id_ex_en      = 1'b0;
                        w_ctrl.ex_mem_bubble = 1'b1;
                        w_cnt_dec            = 1'b1;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    assign pc_en         = w_ctrl.pc_en;
    assign if_id_en      = w_ctrl.if_id_en;
    assign if_id_flush   = w_ctrl.if_id_flush;
    assign id_ex_en      = w_ctrl.id_ex_en;
    assign id_ex_bubble  = w_ctrl.id_ex_bubble;
    assign ex_mem_bubble = w_ctrl.ex_mem_bubble;
    assign mc_busy       = rst && (r_state == ST_MC_BUSY);

`ifdef HAZ_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_ctrl.pc_en && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_ctrl.if_id_flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MC_LATENCY=4).
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       ex_multicycle;
    logic       ex_branch_taken;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_bubble;
    logic       ex_mem_bubble;
    logic       mc_busy;
`ifdef HAZ_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, mc_busy}
    localparam logic [6:0] NORM     = 7'b1101000;
    localparam logic [6:0] NORM_B   = 7'b1101001;
    localparam logic [6:0] FREEZE   = 7'b0000010;
    localparam logic [6:0] FREEZE_B = 7'b0000011;
    localparam logic [6:0] FLUSH    = 7'b1111100;
    localparam logic [6:0] LU       = 7'b0001100;

    logic [6:0] obs;
    assign obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, mc_busy};

    hazard_stall_ctrl #(
        .MC_LATENCY (4),
        .CNT_W      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_multicycle   (ex_multicycle),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_bubble   (ex_mem_bubble),
        .mc_busy         (mc_busy)
`ifdef HAZ_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic mem_read, input logic [4:0] xrt,
                         input logic mc, input logic br);
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = uses_rt;
        ex_mem_read     = mem_read;
        ex_rt           = xrt;
        ex_multicycle   = mc;
        ex_branch_taken = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        check("reset_forces_neutral", NORM);
        tick();
        tick();
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("after_reset_normal", NORM);

        // Load-use on rs: one stall cycle then normal.
        tick();
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        check("lu_rs_stall", LU);
        tick();
        drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
        check("lu_rs_release", NORM);

        // $0 never stalls; rt only compared when used.
        tick();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        check("lu_reg_zero", NORM);
        drive(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        check("lu_rt_unused", NORM);
        drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        check("lu_rt_used", LU);
        drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        check("lu_no_match", NORM);

        // Multi-cycle with ex_multicycle held high across the whole sequence.
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("mc_t0_start", FREEZE);
        tick();
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        check("mc_t1_ignores_br_lu", FREEZE_B);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("mc_t2_freeze", FREEZE_B);
        tick();
        check("mc_t3_release", NORM_B);
        tick();
        check("mc_backtoback_start", FREEZE);
        tick();
        check("mc_b2b_busy_cnt2", FREEZE_B);

        // Reset while busy with cnt=2.
        rst = 1'b0;
        #1;
        check("reset_mid_busy_neutral", NORM);
        tick();
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("post_reset_run", NORM);
        tick();
        check("post_reset_no_residual", NORM);

        // Branch flush for exactly one cycle.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        check("branch_flush", FLUSH);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("branch_after", NORM);

        // Priority: branch over load-use; multi-cycle over branch.
        drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1);
        check("prio_br_over_lu", FLUSH);
        drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1);
        check("prio_mc_over_br", FREEZE);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("prio_mc_busy1", FREEZE_B);
        tick();
        check("prio_mc_busy2", FREEZE_B);
        tick();
        check("prio_mc_exit", NORM_B);
        tick();
        check("prio_mc_run", NORM);

`ifdef HAZ_STATS_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check16("stats_reset_stall", stall_cycles, 16'd0);
        check16("stats_reset_flush", flush_count, 16'd0);
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check16("stats_stall_4", stall_cycles, 16'd4);
        check16("stats_flush_1", flush_count, 16'd1);
        drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
        repeat (70000) @(posedge clk);
        #1;
        check16("stats_stall_sat", stall_cycles, 16'hFFFF);
        check16("stats_flush_hold", flush_count, 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
